imem_loadable: RTL and testbench
================================

Name: imem_loadable

Overview:
- Parametrised, synchronous successor to the pipeline's hard-coded instruction ROM.
- Serves the IF stage with a registered one-cycle fetch, honouring pipeline stall and a supervisor PC bit.
- Adds a byte-stream loader FSM, fed from the UART receive path, that writes a new program into the word array at run time.
- Returns a configurable default instruction for out-of-range or misaligned fetches.

Parameters:
- ADDR_BITS, 8, log2 of word depth; array holds 2^ADDR_BITS 32-bit words.
- DEFAULT_INSTR, 32'h08000003, word returned on out-of-range/misaligned fetch (j to word 3).
- BIG_ENDIAN, 1, 1: first loaded byte goes to [31:24]; 0: first byte goes to [7:0].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_addr  in  32  byte PC from IF stage.
- fetch_en  in  1  fetch request this cycle.
- stall  in  1  hold current instr/instr_valid.
- instr  out  32  fetched instruction, registered.
- instr_valid  out  1  instr holds a fetch result.
- addr_err  out  1  registered with instr; last fetch was out of range or misaligned.
- load_start  in  1  one-cycle pulse that begins a program load.
- load_byte  in  8  loader data byte.
- load_byte_valid  in  1  load_byte valid this cycle; one byte accepted per cycle.
- load_busy  out  1  loader FSM not IDLE.
- load_done  out  1  one-cycle pulse on load completion.
- load_overflow  out  1  sticky; count exceeded depth. Cleared by the next load_start or by reset.

Behaviour:
- Reset values: instr=DEFAULT_INSTR, instr_valid=0, addr_err=0, load_busy=0, load_done=0, load_overflow=0. FSM=IDLE, counters=0. Array contents are not reset.
- Index = fetch_addr[ADDR_BITS+1:2].
  - fetch_addr[31] (supervisor bit) is ignored.
  - Out of range: any bit of fetch_addr[30:ADDR_BITS+2] set.
  - Misaligned: fetch_addr[1:0] != 0.
- Fetch, evaluated at each clk edge when FSM=IDLE:
  - stall=1: instr, instr_valid and addr_err hold (stall wins over fetch_en).
  - fetch_en=1, stall=0: instr <= mem[index], or DEFAULT_INSTR if out of range or misaligned; addr_err <= that condition; instr_valid <= 1. Latency is exactly 1 cycle.
  - fetch_en=0, stall=0: instr_valid <= 0; instr and addr_err hold.
- Fetch while FSM != IDLE: instr_valid <= 0; instr <= DEFAULT_INSTR; fetch requests are dropped, not queued.
- Loader FSM states: IDLE, CNT_HI, CNT_LO, DATA, DONE.
  - IDLE + load_start -> CNT_HI. Clears load_overflow, word_ptr, byte_idx.
  - CNT_HI: accepted byte -> count[15:8]; go to CNT_LO.
  - CNT_LO: accepted byte -> count[7:0]. Go to DONE if count==0, else DATA.
  - DATA: each accepted byte is shifted into the word per BIG_ENDIAN. byte_idx counts 0..3, wrapping.
    - On the 4th byte: write the word to mem[word_ptr] in the same edge if word_ptr < 2^ADDR_BITS; otherwise discard and set load_overflow.
    - Then word_ptr++ and words_left--.
    - words_left reaching 0 -> DONE.
  - DONE: load_done=1 for exactly one cycle, then IDLE.
- load_start outside IDLE is ignored. load_byte_valid in IDLE or DONE is ignored.
- load_busy=1 in every state except IDLE, combinationally from state.
- Partial words (fewer than 4 bytes) are never written.
- Reset mid-load: FSM -> IDLE immediately. Words already written persist; the partial word is lost; load_done is not pulsed.
- word_ptr is ADDR_BITS+1 wide so overflow detection does not wrap. Count is 16-bit unsigned.
- Fetch reads and loader writes never share a cycle, because fetch is disabled outside IDLE. No read/write collision logic is required.
- After load_done, the next fetch returns newly loaded contents with no extra cycle.

Test Plan:
- Reset, then fetch_en=1 with fetch_addr=0x00000400 (ADDR_BITS=8) -> next cycle instr=0x08000003, addr_err=1, instr_valid=1.
- load_start; bytes 00 02 | 20 11 00 01 | 8C 88 00 20 (BIG_ENDIAN=1) -> load_done pulses one cycle after the final byte. Fetch 0x0 -> 0x20110001; fetch 0x80000004 -> 0x8C880020, addr_err=0.
- Same load with BIG_ENDIAN=0, fetch 0x0 -> 0x01001120.
- Fetch 0x4 with stall=1 during the next 3 cycles while fetch_addr changes to 0x0 -> instr holds the 0x4 word and instr_valid stays 1. Release stall -> 0x0 word after 1 cycle.
- Load with count=0x0101 at ADDR_BITS=8, all bytes streamed -> words 0..255 written, load_overflow=1, load_done pulses, word 0 not overwritten by word 256.
- Assert reset after 6 data bytes of a 3-word load -> load_busy=0 immediately, load_done never pulses; word 0 updated, word 1 unchanged; misaligned fetch 0x2 -> DEFAULT_INSTR, addr_err=1.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory: registered one-cycle fetch for the IF stage plus a
// byte-stream loader (16-bit word count, then data) that rewrites the word array.
module imem_loadable #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter logic [31:0] DEFAULT_INSTR = 32'h0800_0003,
    parameter bit          BIG_ENDIAN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_en,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        addr_err,
    input  logic        load_start,
    input  logic [7:0]  load_byte,
    input  logic        load_byte_valid,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_mem [DEPTH];
    logic [7:0]         r_count_hi;
    logic [15:0]        r_words_left;
    logic [ADDR_BITS:0] r_word_ptr;
    logic [1:0]         r_byte_idx;
    logic [31:0]        r_word;
    logic               r_overflow;
    logic [31:0]        r_instr;
    logic               r_instr_valid;
    logic               r_addr_err;

    // The supervisor bit is masked off before range checking.
    logic [31:0]          w_phys_addr;
    logic [ADDR_BITS-1:0] w_index;
    logic                 w_addr_bad;
    logic [15:0]          w_count;
    logic [31:0]          w_next_word;
    logic                 w_word_done;
    logic                 w_ptr_in_range;
    logic                 w_mem_we;

    assign w_phys_addr    = fetch_addr & 32'h7FFF_FFFF;
    assign w_index        = w_phys_addr[ADDR_BITS+1:2];
    assign w_addr_bad     = ((w_phys_addr >> (ADDR_BITS + 2)) != 32'd0) || (w_phys_addr[1:0] != 2'b00);
    assign w_count        = {r_count_hi, load_byte};
    assign w_next_word    = BIG_ENDIAN ? {r_word[23:0], load_byte} : {load_byte, r_word[31:8]};
    assign w_word_done    = (r_state == S_DATA) && load_byte_valid && (r_byte_idx == 2'd3);
    assign w_ptr_in_range = ~r_word_ptr[ADDR_BITS];
    assign w_mem_we       = w_word_done && w_ptr_in_range;

    // Loader state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Loader next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start) w_next_state = S_CNT_HI;
                else            w_next_state = S_IDLE;
            end
            S_CNT_HI: begin
                if (load_byte_valid) w_next_state = S_CNT_LO;
                else                 w_next_state = S_CNT_HI;
            end
            S_CNT_LO: begin
                if (load_byte_valid) w_next_state = (w_count == 16'd0) ? S_DONE : S_DATA;
                else                 w_next_state = S_CNT_LO;
            end
            S_DATA: begin
                if (w_word_done && (r_words_left == 16'd1)) w_next_state = S_DONE;
                else                                        w_next_state = S_DATA;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Loader datapath: count capture, byte assembly, pointer and overflow tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count_hi   <= 8'd0;
            r_words_left <= 16'd0;
            r_word_ptr   <= '0;
            r_byte_idx   <= 2'd0;
            r_word       <= 32'd0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_overflow <= 1'b0;
                        r_word_ptr <= '0;
                        r_byte_idx <= 2'd0;
                        r_word     <= 32'd0;
                    end
                end
                S_CNT_HI: begin
                    if (load_byte_valid) r_count_hi <= load_byte;
                end
                S_CNT_LO: begin
                    if (load_byte_valid) r_words_left <= w_count;
                end
                S_DATA: begin
                    if (load_byte_valid) begin
                        r_word     <= w_next_word;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_words_left <= r_words_left - 16'd1;
                            // Pointer saturates at DEPTH so a long stream never wraps onto word 0.
                            if (w_ptr_in_range) r_word_ptr <= r_word_ptr + 1'b1;
                            else                r_overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Word array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_word_ptr[ADDR_BITS-1:0]] <= w_next_word;
        end
    end

    // Registered fetch port; disabled while the loader owns the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr       <= DEFAULT_INSTR;
            r_instr_valid <= 1'b0;
            r_addr_err    <= 1'b0;
        end else if (r_state != S_IDLE) begin
            r_instr       <= DEFAULT_INSTR;
            r_instr_valid <= 1'b0;
        end else if (stall) begin
            r_instr_valid <= r_instr_valid;
        end else if (fetch_en) begin
            r_instr       <= w_addr_bad ? DEFAULT_INSTR : r_mem[w_index];
            r_addr_err    <= w_addr_bad;
            r_instr_valid <= 1'b1;
        end else begin
            r_instr_valid <= 1'b0;
        end
    end

    assign instr         = r_instr;
    assign instr_valid   = r_instr_valid;
    assign addr_err      = r_addr_err;
    assign load_busy     = (r_state != S_IDLE);
    assign load_done     = (r_state == S_DONE);
    assign load_overflow = r_overflow;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: big- and little-endian instances share stimulus and are
// checked against an array model of loaded words and a fetch/stall output model.
module tb_imem_loadable;

    localparam logic [31:0] DEF = 32'h0800_0003;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_en, stall, load_start, load_byte_valid;
    logic [7:0]  load_byte;
    logic [31:0] instr_be, instr_le;
    logic        valid_be, valid_le, err_be, err_le;
    logic        busy_be, busy_le, done_be, done_le, ovf_be, ovf_le;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_be [256];
    logic [31:0] m_le [256];
    bit          known [256];
    logic [31:0] e_be, e_le;
    logic        e_valid, e_err;
    bit          e_known;
    logic [7:0]  data_q [$];

    imem_loadable #(.ADDR_BITS(8), .DEFAULT_INSTR(DEF), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_en(fetch_en), .stall(stall),
        .instr(instr_be), .instr_valid(valid_be), .addr_err(err_be),
        .load_start(load_start), .load_byte(load_byte), .load_byte_valid(load_byte_valid),
        .load_busy(busy_be), .load_done(done_be), .load_overflow(ovf_be));

    imem_loadable #(.ADDR_BITS(8), .DEFAULT_INSTR(DEF), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_en(fetch_en), .stall(stall),
        .instr(instr_le), .instr_valid(valid_le), .addr_err(err_le),
        .load_start(load_start), .load_byte(load_byte), .load_byte_valid(load_byte_valid),
        .load_busy(busy_le), .load_done(done_le), .load_overflow(ovf_le));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One fetch-port cycle, then compare against the fetch/stall model.
    task automatic step(input logic fen, input logic stl, input logic [31:0] addr, input string tag);
        logic [7:0] idx;
        logic       bad;
        fetch_en = fen; stall = stl; fetch_addr = addr;
        tick();
        fetch_en = 1'b0; stall = 1'b0;
        if (!stl) begin
            if (fen) begin
                idx = addr[9:2];
                bad = (addr[1:0] != 2'b00) || (addr[30:10] != 21'd0);
                e_err = bad; e_valid = 1'b1;
                if (bad) begin
                    e_be = DEF; e_le = DEF; e_known = 1'b1;
                end else begin
                    e_be = m_be[idx]; e_le = m_le[idx]; e_known = known[idx];
                end
            end else begin
                e_valid = 1'b0;
            end
        end
        check({tag, "_valid"}, {31'd0, valid_be}, {31'd0, e_valid});
        check({tag, "_valid_le"}, {31'd0, valid_le}, {31'd0, e_valid});
        check({tag, "_err"}, {31'd0, err_be}, {31'd0, e_err});
        if (e_known) begin
            check({tag, "_instr_be"}, instr_be, e_be);
            check({tag, "_instr_le"}, instr_le, e_le);
        end
    endtask

    // Streams count + data_q through the loader with random idle gaps, then updates the model.
    task automatic run_load(input logic [15:0] cnt, input int gap_pct, input string tag);
        logic [7:0] stream [$];
        int         gaps;
        logic       exp_ovf;
        stream = {cnt[15:8], cnt[7:0]};
        foreach (data_q[i]) stream.push_back(data_q[i]);
        fetch_en = 1'b0; stall = 1'b0; load_byte_valid = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check({tag, "_busy_start"}, {31'd0, busy_be}, 32'd1);
        check({tag, "_ovf_clr"}, {31'd0, ovf_be}, 32'd0);
        for (int i = 0; i < stream.size(); i++) begin
            gaps = ($urandom_range(99) < gap_pct) ? int'($urandom_range(1, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                fetch_en = 1'b1; fetch_addr = $urandom & 32'h0000_03FC;
                tick();
                fetch_en = 1'b0;
                check({tag, "_gap_valid"}, {31'd0, valid_be}, 32'd0);
                check({tag, "_gap_instr"}, instr_be, DEF);
                check({tag, "_gap_done"}, {31'd0, done_be}, 32'd0);
            end
            load_byte_valid = 1'b1; load_byte = stream[i];
            tick();
            load_byte_valid = 1'b0;
            if (i == stream.size() - 1) begin
                check({tag, "_done_be"}, {31'd0, done_be}, 32'd1);
                check({tag, "_done_le"}, {31'd0, done_le}, 32'd1);
            end else begin
                check({tag, "_done_early"}, {31'd0, done_be}, 32'd0);
            end
        end
        for (int k = 0; k < int'(cnt); k++) begin
            if (k < 256) begin
                m_be[k] = {data_q[4*k], data_q[4*k+1], data_q[4*k+2], data_q[4*k+3]};
                m_le[k] = {data_q[4*k+3], data_q[4*k+2], data_q[4*k+1], data_q[4*k]};
                known[k] = 1'b1;
            end
        end
        exp_ovf = (cnt > 16'd256);
        e_valid = 1'b0; e_be = DEF; e_le = DEF; e_known = 1'b1;
        tick();
        check({tag, "_done_once"}, {31'd0, done_be}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy_be}, 32'd0);
        check({tag, "_ovf_be"}, {31'd0, ovf_be}, {31'd0, exp_ovf});
        check({tag, "_ovf_le"}, {31'd0, ovf_le}, {31'd0, exp_ovf});
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 21'd0, 8'($urandom_range(0, 255)), 2'b00};
        case ($urandom_range(0, 5))
            0:       a[1:0] = 2'($urandom_range(1, 3));
            1:       a[10 + $urandom_range(0, 20)] = 1'b1;
            default: a = a;
        endcase
        return a;
    endfunction

    initial begin
        logic [15:0] cnt;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        reset = 1'b1; fetch_addr = 32'd0; fetch_en = 1'b0; stall = 1'b0;
        load_start = 1'b0; load_byte = 8'd0; load_byte_valid = 1'b0;
        tick(); tick();
        check("rst_instr", instr_be, DEF);
        check("rst_valid", {31'd0, valid_be}, 32'd0);
        check("rst_err", {31'd0, err_be}, 32'd0);
        check("rst_busy", {31'd0, busy_be}, 32'd0);
        check("rst_done", {31'd0, done_be}, 32'd0);
        check("rst_ovf", {31'd0, ovf_le}, 32'd0);
        e_be = DEF; e_le = DEF; e_valid = 1'b0; e_err = 1'b0; e_known = 1'b1;
        reset = 1'b0;
        tick();

        step(1'b1, 1'b0, 32'h0000_0400, "oor");
        check("oor_const", instr_be, DEF);
        check("oor_err_const", {31'd0, err_be}, 32'd1);

        data_q = {8'h20, 8'h11, 8'h00, 8'h01, 8'h8C, 8'h88, 8'h00, 8'h20};
        run_load(16'd2, 0, "ld2");
        step(1'b1, 1'b0, 32'h0000_0000, "f0");
        check("f0_be_const", instr_be, 32'h2011_0001);
        check("f0_le_const", instr_le, 32'h0100_1120);
        step(1'b1, 1'b0, 32'h8000_0004, "f4sup");
        check("f4sup_const", instr_be, 32'h8C88_0020);

        step(1'b1, 1'b0, 32'h0000_0004, "pre_stall");
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b1, 32'h0000_0000, "stall");
        check("stall_hold_const", instr_be, 32'h8C88_0020);
        step(1'b1, 1'b0, 32'h0000_0000, "unstall");

        data_q.delete();
        for (int i = 0; i < 257 * 4; i++) data_q.push_back(8'($urandom));
        run_load(16'h0101, 0, "ovf");
        step(1'b1, 1'b0, 32'h0000_0000, "ovf_w0");
        step(1'b1, 1'b0, 32'h0000_03FC, "ovf_w255");

        for (int l = 0; l < 4; l++) begin
            cnt = 16'($urandom_range(0, 12));
            data_q.delete();
            for (int i = 0; i < int'(cnt) * 4; i++) data_q.push_back(8'($urandom));
            run_load(cnt, 30, "rld");
            for (int c = 0; c < 40; c++)
                step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), rand_addr(), "rnd");
        end

        data_q.delete();
        for (int i = 0; i < 6; i++) data_q.push_back(8'($urandom));
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_byte_valid = 1'b1;
        load_byte = 8'h00; tick();
        load_byte = 8'h03; tick();
        foreach (data_q[i]) begin
            load_byte = data_q[i];
            tick();
        end
        load_byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy_be}, 32'd0);
        check("midrst_done", {31'd0, done_be}, 32'd0);
        m_be[0] = {data_q[0], data_q[1], data_q[2], data_q[3]};
        m_le[0] = {data_q[3], data_q[2], data_q[1], data_q[0]};
        e_be = DEF; e_le = DEF; e_valid = 1'b0; e_err = 1'b0; e_known = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", {31'd0, done_be}, 32'd0);
        end
        step(1'b1, 1'b0, 32'h0000_0000, "midrst_w0");
        step(1'b1, 1'b0, 32'h0000_0004, "midrst_w1");
        step(1'b1, 1'b0, 32'h0000_0002, "midrst_mis");
        check("midrst_mis_const", instr_be, DEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
